// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: tag allocation, result capture, in-order retirement and mispredict flush.
// Optional define ROB_WB_BYPASS_EN forwards same-cycle writebacks to the query ports.
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  output logic [TAG_W-1:0] issue_tag,
  output logic             rob_full,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [31:0]      wb_val,
  input  logic             wb_mispredict,
  input  logic [31:0]      wb_target,
  input  logic [TAG_W-1:0] query_tag_1,
  output logic             query_ready_1,
  output logic [31:0]      query_val_1,
  input  logic [TAG_W-1:0] query_tag_2,
  output logic             query_ready_2,
  output logic [31:0]      query_val_2,
  output logic [4:0]       commit_reg,
  output logic [31:0]      commit_val,
  output logic [4:0]       commit_q_reg,
  output logic [31:0]      commit_q_tag,
  output logic             flush_out,
  output logic [31:0]      flush_pc
);

  localparam int CNT_W = TAG_W + 1;

  logic [ROB_DEPTH-1:0] busy_q, done_q, mis_q;
  logic [4:0]           rd_mem     [ROB_DEPTH];
  logic [31:0]          val_mem    [ROB_DEPTH];
  logic [31:0]          target_mem [ROB_DEPTH];
  logic [TAG_W-1:0]     head_q, tail_q;
  logic [CNT_W-1:0]     count_q;

  logic commit_fire, flush_now, issue_fire, wb_hit;

  assign rob_full     = (count_q == CNT_W'(ROB_DEPTH));
  assign issue_tag    = tail_q;
  assign commit_fire  = busy_q[head_q] & done_q[head_q];
  assign flush_now    = commit_fire & mis_q[head_q];
  // Full is judged on the pre-edge count, so a slot freed by this cycle's commit is not reusable yet.
  assign issue_fire   = issue_valid & ~rob_full & ~flush_now;
  assign wb_hit       = wb_valid & busy_q[wb_tag];
  assign commit_q_reg = commit_reg;

  // NOTE: sequential state uses non-blocking assignments only; later assignments in the
  // block (commit clear, flush) intentionally override earlier ones for the same bit.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q       <= '0;
      done_q       <= '0;
      mis_q        <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_reg   <= '0;
      commit_val   <= '0;
      commit_q_tag <= '0;
      flush_out    <= 1'b0;
      flush_pc     <= '0;
    end else if (rdy_in) begin
      if (wb_hit) begin
        done_q[wb_tag] <= 1'b1;
        mis_q[wb_tag]  <= wb_mispredict;
      end
      if (commit_fire) begin
        busy_q[head_q] <= 1'b0;
        done_q[head_q] <= 1'b0;
        head_q         <= head_q + TAG_W'(1);
      end
      if (issue_fire) begin
        busy_q[tail_q] <= 1'b1;
        done_q[tail_q] <= 1'b0;
        mis_q[tail_q]  <= 1'b0;
        tail_q         <= tail_q + TAG_W'(1);
      end
      count_q <= count_q + CNT_W'(issue_fire) - CNT_W'(commit_fire);

      commit_reg   <= commit_fire ? rd_mem[head_q]  : '0;
      commit_val   <= commit_fire ? val_mem[head_q] : '0;
      commit_q_tag <= commit_fire ? 32'(head_q)     : '0;
      flush_out    <= flush_now;
      flush_pc     <= flush_now ? target_mem[head_q] : '0;

      if (flush_now) begin
        busy_q  <= '0;
        done_q  <= '0;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end
    end
  end

  // NOTE: payload storage has no reset; busy/done qualify every read, so its contents
  // before the first write are never observed.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (issue_fire) rd_mem[tail_q] <= issue_rd;
      if (wb_hit) begin
        val_mem[wb_tag]    <= wb_val;
        target_mem[wb_tag] <= wb_target;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    query_ready_1 = busy_q[query_tag_1] & done_q[query_tag_1];
    query_val_1   = val_mem[query_tag_1];
    query_ready_2 = busy_q[query_tag_2] & done_q[query_tag_2];
    query_val_2   = val_mem[query_tag_2];
`ifdef ROB_WB_BYPASS_EN
    if (wb_hit && (wb_tag == query_tag_1)) begin
      query_ready_1 = 1'b1;
      query_val_1   = wb_val;
    end
    if (wb_hit && (wb_tag == query_tag_2)) begin
      query_ready_2 = 1'b1;
      query_val_2   = wb_val;
    end
`endif
  end

endmodule
